// File: rtl/instr_encode.sv
// instr_encode: two-stage valid/ready pipeline that assembles RV32I
// instruction words from a field bundle.
// S1 registers the raw bundle. S2 holds the assembled word and its error flag.
// An illegal bundle is replaced by a NOP and flagged on err.
module instr_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0]       FMT_R   = 3'd0;
    localparam logic [2:0]       FMT_I   = 3'd1;
    localparam logic [2:0]       FMT_S   = 3'd2;
    localparam logic [2:0]       FMT_B   = 3'd3;
    localparam logic [2:0]       FMT_U   = 3'd4;
    localparam logic [2:0]       FMT_J   = 3'd5;
    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1: registered bundle
    logic        r_s1_valid;
    logic [2:0]  r_fmt;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_imm;

    // Stage 2: assembled word
    logic             r_s2_valid;
    logic [31:0]      r_instr;
    logic             r_err;
    logic [CNT_W-1:0] r_enc_count;
    logic [CNT_W-1:0] r_err_count;

    logic        w_s1_adv;
    logic        w_s2_adv;
    logic        w_out_hs;
    logic [31:0] w_word;
    logic        w_fmt_bad;
    logic        w_imm_bad;
    logic        w_err;
    logic [31:0] w_instr;
    logic        w_hi11_same;
    logic        w_hi12_same;
    logic        w_hi20_same;

    // A stage may take new data when it is empty or its content moves on.
    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_out_hs = r_s2_valid & out_ready;

    // Sign-extension checks: the upper bits must all be copies of the sign bit.
    assign w_hi11_same = (&r_imm[31:11]) | ~(|r_imm[31:11]);
    assign w_hi12_same = (&r_imm[31:12]) | ~(|r_imm[31:12]);
    assign w_hi20_same = (&r_imm[31:20]) | ~(|r_imm[31:20]);

    // Scatter the fields by format and flag immediates that do not fit.
    always_comb begin
        w_word    = 32'h0;
        w_fmt_bad = 1'b0;
        w_imm_bad = 1'b0;
        case (r_fmt)
            FMT_R: begin
                w_word = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
            end
            FMT_I: begin
                w_word    = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
                w_imm_bad = ~w_hi11_same;
            end
            FMT_S: begin
                w_word    = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
                w_imm_bad = ~w_hi11_same;
            end
            FMT_B: begin
                w_word    = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                             r_imm[4:1], r_imm[11], r_opcode};
                w_imm_bad = r_imm[0] | ~w_hi12_same;
            end
            FMT_U: begin
                w_word    = {r_imm[31:12], r_rd, r_opcode};
                w_imm_bad = |r_imm[11:0];
            end
            FMT_J: begin
                w_word    = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
                w_imm_bad = r_imm[0] | ~w_hi20_same;
            end
            default: begin
                w_fmt_bad = 1'b1;
            end
        endcase
    end

    assign w_err   = w_fmt_bad | w_imm_bad | (r_opcode[1:0] != 2'b11);
    assign w_instr = w_err ? NOP : w_word;

    // Stage 1: capture the bundle whenever the stage is free to advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_fmt      <= 3'd0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7   <= 7'd0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_imm      <= 32'd0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_fmt    <= fmt;
                r_opcode <= opcode;
                r_funct3 <= funct3;
                r_funct7 <= funct7;
                r_rd     <= rd;
                r_rs1    <= rs1;
                r_rs2    <= rs2;
                r_imm    <= imm;
            end
        end
    end

    // Stage 2: hold the assembled word until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_instr    <= 32'd0;
            r_err      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_instr <= w_instr;
                r_err   <= w_err;
            end
        end
    end

    // Saturating handshake counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_out_hs) begin
            if (r_enc_count != CNT_MAX) begin
                r_enc_count <= r_enc_count + CNT_ONE;
            end
            if (r_err && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign instr     = r_instr;
    assign err       = r_err;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

endmodule
